// File: rtl/bm_load_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : bm_load_sched_if
// Description : Request and chunk-loader signals of the bias-load scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface bm_load_sched_if #(
   parameter int AW = 10
) ();
   logic          start_pulse;
   logic [31:0]   d_addr;
   logic [AW-1:0] c_addr;
   logic [31:0]   n_bytes;
   logic          done_pulse;
   logic          err_pulse;
   logic          busy;
   logic          sub_start_pulse;
   logic [31:0]   sub_d_addr;
   logic [AW-1:0] sub_c_addr;
   logic [31:0]   sub_n_bytes;
   logic          sub_done_pulse;

   // Scheduler view
   modport slave (
      input  start_pulse, d_addr, c_addr, n_bytes, sub_done_pulse,
      output done_pulse, err_pulse, busy,
             sub_start_pulse, sub_d_addr, sub_c_addr, sub_n_bytes
   );

   // Requester plus loader view
   modport master (
      output start_pulse, d_addr, c_addr, n_bytes, sub_done_pulse,
      input  done_pulse, err_pulse, busy,
             sub_start_pulse, sub_d_addr, sub_c_addr, sub_n_bytes
   );
endinterface
`default_nettype wire

// File: rtl/bm_load_sched.sv
`default_nettype none
// ============================================================================
// Module      : bm_load_sched
// Description : Splits a bias-load request into boundary-safe chunks and runs
//               the DRAM->BM loader once per chunk.
// Revision    : 1.0 - initial release
// ============================================================================
module bm_load_sched #(
   parameter int MAX_CHUNK_BYTES = 4096,
   parameter int BEAT_BYTES      = 64,
   parameter int AW              = 10
) (
   input  wire logic      clk,
   input  wire logic      rstn,
   bm_load_sched_if.slave bus
);
   localparam int          c_BEAT_SHIFT = $clog2(BEAT_BYTES);
   localparam logic [31:0] c_BEAT_MASK  = 32'(BEAT_BYTES - 1);
   localparam logic [32:0] c_CHUNK      = 33'(MAX_CHUNK_BYTES);
   localparam logic [32:0] c_CHUNK_MASK = 33'(MAX_CHUNK_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [31:0]   r_rem;
   logic [31:0]   r_da;
   logic [AW-1:0] r_ca;
   logic [31:0]   r_sub_d;
   logic [AW-1:0] r_sub_c;
   logic [31:0]   r_sub_n;
   logic          r_err;
   logic          r_rej;
   logic          w_misaligned;
   logic          w_accept;
   logic [32:0]   w_room;
   logic [31:0]   w_chunk;

   assign w_misaligned = ((bus.n_bytes | bus.d_addr) & c_BEAT_MASK) != 32'd0;
   assign w_accept     = bus.start_pulse && (r_state == S_IDLE) && !w_misaligned;

   // Room left before the next chunk boundary; the min always fits 32 bits
   // because rem does.
   assign w_room  = c_CHUNK - ({1'b0, r_da} & c_CHUNK_MASK);
   assign w_chunk = ({1'b0, r_rem} < w_room) ? r_rem : w_room[31:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A zero-length request passes through CALC so it finishes in FIN.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_CALC;
         S_CALC:  w_next = (r_rem == 32'd0) ? S_FIN : S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (bus.sub_done_pulse) w_next = (r_rem != 32'd0) ? S_CALC : S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rem   <= '0;
         r_da    <= '0;
         r_ca    <= '0;
         r_sub_d <= '0;
         r_sub_c <= '0;
         r_sub_n <= '0;
         r_err   <= 1'b0;
         r_rej   <= 1'b0;
      end else begin
         r_err <= bus.start_pulse && ((r_state != S_IDLE) || w_misaligned);
         r_rej <= bus.start_pulse && (r_state == S_IDLE) && w_misaligned;
         if (w_accept) begin
            r_rem <= bus.n_bytes;
            r_da  <= bus.d_addr;
            r_ca  <= bus.c_addr;
         end
         if ((r_state == S_CALC) && (r_rem != 32'd0)) begin
            r_sub_d <= r_da;
            r_sub_c <= r_ca;
            r_sub_n <= w_chunk;
         end
         if (r_state == S_ISSUE) begin
            r_rem <= r_rem - r_sub_n;
            r_da  <= r_da + r_sub_n;
            r_ca  <= r_ca + AW'(r_sub_n >> c_BEAT_SHIFT);
         end
      end
   end

   assign bus.busy            = (r_state == S_CALC) || (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign bus.sub_start_pulse = (r_state == S_ISSUE);
   assign bus.done_pulse      = (r_state == S_FIN) || r_rej;
   assign bus.err_pulse       = r_err;
   assign bus.sub_d_addr      = r_sub_d;
   assign bus.sub_c_addr      = r_sub_c;
   assign bus.sub_n_bytes     = r_sub_n;

endmodule
`default_nettype wire

// File: tb/tb_bm_load_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bm_load_sched
// Description : Scoreboard bench for bm_load_sched with a 5-cycle loader model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bm_load_sched;
   localparam int AW     = 10;
   localparam int c_BEAT = 64;
   localparam int c_MAX  = 4096;

   typedef struct {
      int            cyc;
      logic [31:0]   d;
      logic [AW-1:0] c;
      logic [31:0]   n;
   } chunk_t;

   typedef struct {
      int   cyc;
      logic err;
   } done_t;

   logic   clk  = 1'b0;
   logic   rstn = 1'b0;
   int     cyc  = 0;
   int     n_chk = 0;
   int     n_err = 0;
   chunk_t chunk_q[$];
   done_t  done_q[$];
   int     err_q[$];

   bm_load_sched_if #(.AW(AW)) bus ();

   bm_load_sched #(
      .MAX_CHUNK_BYTES(c_MAX),
      .BEAT_BYTES     (c_BEAT),
      .AW             (AW)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_chunk(input int t, input logic [31:0] d, input logic [31:0] c,
                             input logic [31:0] n);
      chunk_t e;
      e.cyc = t;
      e.d   = d;
      e.c   = AW'(c);
      e.n   = n;
      chunk_q.push_back(e);
   endtask

   task automatic push_done(input int t, input logic err);
      done_t e;
      e.cyc = t;
      e.err = err;
      done_q.push_back(e);
   endtask

   // Reference: chunk k issues at T+2+7k, done one cycle after the last sub_done.
   task automatic model_req(input int t, input logic [31:0] d, input logic [31:0] c,
                            input logic [31:0] n);
      longint        rem  = longint'(n);
      longint        da   = longint'(d);
      longint        room;
      longint        ch;
      logic [AW-1:0] ca   = AW'(c);
      int            k    = 0;
      if ((n % c_BEAT) != 0 || (d % c_BEAT) != 0) begin
         push_done(t + 1, 1'b1);
      end else if (n == 0) begin
         push_done(t + 2, 1'b0);
      end else begin
         while (rem > 0) begin
            room = c_MAX - (da % c_MAX);
            ch   = (rem < room) ? rem : room;
            push_chunk(t + 2 + 7 * k, 32'(da), 32'(ca), 32'(ch));
            da   = da + ch;
            ca   = ca + AW'(ch / c_BEAT);
            rem  = rem - ch;
            k++;
         end
         push_done(t + 2 + 7 * (k - 1) + 6, 1'b0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) step();
   endtask

   // Called just after a rising edge; the request is sampled on the next one.
   task automatic req(input logic [31:0] d, input logic [31:0] c, input logic [31:0] n,
                      output int t);
      bus.start_pulse = 1'b1;
      bus.d_addr      = d;
      bus.c_addr      = AW'(c);
      bus.n_bytes     = n;
      t               = cyc;
      step();
      bus.start_pulse = 1'b0;
   endtask

   task automatic wait_drain();
      int b = 0;
      while ((chunk_q.size() + done_q.size() + err_q.size()) != 0 && b < 300) begin
         step();
         b++;
      end
      chk("drain_left", 64'(chunk_q.size() + done_q.size() + err_q.size()), 64'd0);
      chunk_q.delete();
      done_q.delete();
      err_q.delete();
      repeat (3) step();
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_done"},      64'(bus.done_pulse),      64'd0);
      chk({pfx, "_err"},       64'(bus.err_pulse),       64'd0);
      chk({pfx, "_busy"},      64'(bus.busy),            64'd0);
      chk({pfx, "_sub_start"}, 64'(bus.sub_start_pulse), 64'd0);
      chk({pfx, "_sub_d"},     64'(bus.sub_d_addr),      64'd0);
      chk({pfx, "_sub_c"},     64'(bus.sub_c_addr),      64'd0);
      chk({pfx, "_sub_n"},     64'(bus.sub_n_bytes),     64'd0);
   endtask

   // Loader: answers each chunk with sub_done five cycles later.
   initial begin
      bus.sub_done_pulse = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.sub_start_pulse === 1'b1) begin
            repeat (5) @(posedge clk);
            #1 bus.sub_done_pulse = 1'b1;
            @(posedge clk);
            #1 bus.sub_done_pulse = 1'b0;
         end
      end
   end

   // Output monitor
   initial begin
      chunk_t ce;
      done_t  de;
      int     ee;
      forever begin
         @(negedge clk);
         if (bus.sub_start_pulse === 1'b1) begin
            if (chunk_q.size() == 0) begin
               chk("chunk_unexpected", 64'd1, 64'd0);
            end else begin
               ce = chunk_q.pop_front();
               chk("chunk_cycle",   64'(cyc),             64'(ce.cyc));
               chk("sub_d_addr",    64'(bus.sub_d_addr),  64'(ce.d));
               chk("sub_c_addr",    64'(bus.sub_c_addr),  64'(ce.c));
               chk("sub_n_bytes",   64'(bus.sub_n_bytes), 64'(ce.n));
               chk("busy_at_chunk", 64'(bus.busy),        64'd1);
            end
         end
         if (bus.done_pulse === 1'b1) begin
            if (done_q.size() == 0) begin
               chk("done_unexpected", 64'd1, 64'd0);
            end else begin
               de = done_q.pop_front();
               chk("done_cycle",   64'(cyc),           64'(de.cyc));
               chk("done_err",     64'(bus.err_pulse), 64'(de.err));
               chk("busy_at_done", 64'(bus.busy),      64'd0);
            end
         end else if (bus.err_pulse === 1'b1) begin
            if (err_q.size() == 0) begin
               chk("err_unexpected", 64'd1, 64'd0);
            end else begin
               ee = err_q.pop_front();
               chk("err_cycle", 64'(cyc), 64'(ee));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation stalled, errors so far %0d", n_err);
      $fatal(1);
   end

   initial begin
      int            t;
      int            t2;
      logic [31:0]   rd;
      logic [31:0]   rc;
      logic [31:0]   rn;
      bus.start_pulse = 1'b0;
      bus.d_addr      = '0;
      bus.c_addr      = '0;
      bus.n_bytes     = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk);
      #1 rstn = 1'b1;
      step();

      // Single chunk, then a start landing on the FIN cycle
      req(32'h1000, 0, 256, t);
      push_chunk(t + 2, 32'h1000, 0, 256);
      push_done(t + 8, 1'b0);
      wait_cyc(t + 8);
      req(32'h40, 0, 64, t2);
      err_q.push_back(t2 + 1);
      wait_drain();

      // Crosses one 4 KiB boundary
      req(32'h0F00, 8, 1024, t);
      push_chunk(t + 2, 32'h0F00, 8, 256);
      push_chunk(t + 9, 32'h1000, 12, 768);
      push_done(t + 15, 1'b0);
      wait_drain();

      // Three chunks, busy must stay high until done
      req(32'h0, 0, 9216, t);
      push_chunk(t + 2,  32'h0000, 0,   4096);
      push_chunk(t + 9,  32'h1000, 64,  4096);
      push_chunk(t + 16, 32'h2000, 128, 1024);
      push_done(t + 22, 1'b0);
      for (int i = 1; i <= 21; i++) begin
         @(negedge clk);
         chk("busy_held", 64'(bus.busy), 64'd1);
      end
      wait_drain();

      // Zero length and misaligned requests
      req(32'h0, 0, 0, t);
      push_done(t + 2, 1'b0);
      wait_drain();
      req(32'h0, 0, 100, t);
      push_done(t + 1, 1'b1);
      wait_drain();
      req(32'h20, 0, 64, t);
      push_done(t + 1, 1'b1);
      wait_drain();

      // Start while waiting on the loader is rejected without disturbing the request
      req(32'h0, 0, 512, t);
      push_chunk(t + 2, 32'h0, 0, 512);
      push_done(t + 8, 1'b0);
      wait_cyc(t + 4);
      req(32'h1000, 5, 128, t2);
      err_q.push_back(t2 + 1);
      wait_drain();

      // Reset during WAIT abandons the request; the late sub_done is ignored
      req(32'h0, 0, 8192, t);
      push_chunk(t + 2, 32'h0, 0, 4096);
      wait_cyc(t + 4);
      rstn = 1'b0;
      @(negedge clk);
      chk_outputs_zero("midrst");
      wait_cyc(t + 6);
      rstn = 1'b1;
      repeat (10) step();
      chk("post_rst_busy",  64'(bus.busy), 64'd0);
      chk("post_rst_queue", 64'(chunk_q.size() + done_q.size() + err_q.size()), 64'd0);
      repeat (2) step();

      // BM entry address wraps at 2^AW
      req(32'h0, 1020, 512, t);
      push_chunk(t + 2, 32'h0, 1020, 512);
      push_done(t + 8, 1'b0);
      wait_drain();
      req(32'h0F80, 1022, 256, t);
      push_chunk(t + 2, 32'h0F80, 1022, 128);
      push_chunk(t + 9, 32'h1000, 0,    128);
      push_done(t + 15, 1'b0);
      wait_drain();

      // A few random aligned requests against the reference model
      for (int i = 0; i < 4; i++) begin
         rd = 32'($urandom_range(0, 255) * c_BEAT);
         rn = 32'($urandom_range(0, 80) * c_BEAT);
         rc = 32'($urandom_range(0, (1 << AW) - 1));
         req(rd, rc, rn, t);
         model_req(t, rd, rc, rn);
         wait_drain();
      end

      step();
      chk("final_queues", 64'(chunk_q.size() + done_q.size() + err_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
